// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem timer: register offsets, CTRL bit
// positions, the register write-enable bundle and a byte-lane merge helper.
package iomem_timer_pkg;

  localparam logic [7:0] TMR_CTRL     = 8'h00;
  localparam logic [7:0] TMR_PRESCALE = 8'h04;
  localparam logic [7:0] TMR_COUNT    = 8'h08;
  localparam logic [7:0] TMR_COMPARE  = 8'h0C;
  localparam logic [7:0] TMR_STATUS   = 8'h10;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  // One strobe per register; status_clr is the already-qualified W1C request.
  typedef struct packed {
    logic ctrl;
    logic prescale;
    logic count;
    logic compare;
    logic status_clr;
  } tmr_we_t;

  // Replace the byte lanes of old_val selected by strb with those of new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// iomem valid/ready bus as seen between the CPU (master) and a responder (slave).
interface iomem_timer_if;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, output wstrb, output addr, output wdata,
                  input  ready, input  rdata);
  modport slave  (input  valid, input  wstrb, input  addr, input  wdata,
                  output ready, output rdata);
endinterface

// File: rtl/iomem_timer_core.sv
// Timer datapath: CTRL, prescaler, COUNT/COMPARE, pending flag and the
// registered interrupt. Register writes arrive as strobes plus merged data.
module iomem_timer_core
  import iomem_timer_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  tmr_we_t               we,
  input  logic [31:0]           wdata,
  output logic [2:0]            ctrl,
  output logic [PRESCALE_W-1:0] prescale,
  output logic [31:0]           count,
  output logic [31:0]           compare,
  output logic                  pending,
  output logic                  irq
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  tick;
  logic                  match;

  assign tick  = ctrl[CTRL_EN] && (pcnt == prescale);
  assign match = tick && (count == compare);

  // CTRL: a bus write overrides the one-shot disable on a match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl <= 3'b000;
    end else if (we.ctrl) begin
      ctrl <= wdata[2:0];
    end else if (match && !ctrl[CTRL_AUTO_RELOAD]) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // PRESCALE register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescale <= '0;
    end else if (we.prescale) begin
      prescale <= wdata[PRESCALE_W-1:0];
    end
  end

  // Prescaler counter: idles at 0 when disabled, restarts on PRESCALE writes and ticks.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pcnt <= '0;
    end else if (we.prescale || !ctrl[CTRL_EN] || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // COUNT: bus write wins; otherwise advance, reload or hold on each tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 32'd0;
    end else if (we.count) begin
      count <= wdata;
    end else if (tick) begin
      if (!match) begin
        count <= count + 32'd1;
      end else if (ctrl[CTRL_AUTO_RELOAD]) begin
        count <= 32'd0;
      end
    end
  end

  // COMPARE register, all ones out of reset so a fresh timer never matches early.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare <= 32'hFFFF_FFFF;
    end else if (we.compare) begin
      compare <= wdata;
    end
  end

  // Pending flag: a match sets it even if software clears it in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else if (match) begin
      pending <= 1'b1;
    end else if (we.status_clr) begin
      pending <= 1'b0;
    end
  end

  // Registered level interrupt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= pending && ctrl[CTRL_IRQ_EN];
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// iomem timer responder: window decode, one-cycle valid/ready handshake,
// read mux and write routing into the timer core.
module iomem_timer
  import iomem_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  iomem_timer_if.slave iomem,
  output logic        irq
);

  logic                  hit;
  logic                  accept;
  logic                  wr;
  logic [7:0]            offset;
  logic [31:0]           rd_val;
  logic [31:0]           wr_data;
  tmr_we_t               we;
  logic [2:0]            ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic                  pending;
  logic                  unused_addr_bits;

  assign hit              = iomem.valid && (iomem.addr[31:8] == BASE_ADDR[31:8]);
  assign accept           = hit && !iomem.ready;
  assign wr               = accept && (iomem.wstrb != 4'b0000);
  assign offset           = {iomem.addr[7:2], 2'b00};
  assign unused_addr_bits = ^iomem.addr[1:0];
  assign wr_data          = merge_bytes(rd_val, iomem.wdata, iomem.wstrb);

  // Register read-back view; unmapped offsets and unused bits read as zero.
  always_comb begin
    rd_val = 32'd0;
    case (offset)
      TMR_CTRL:     rd_val[2:0]            = ctrl;
      TMR_PRESCALE: rd_val[PRESCALE_W-1:0] = prescale;
      TMR_COUNT:    rd_val                 = count;
      TMR_COMPARE:  rd_val                 = compare;
      TMR_STATUS:   rd_val[0]              = pending;
      default:      rd_val                 = 32'd0;
    endcase
  end

  // Route an accepted write to the addressed register.
  always_comb begin
    we = '0;
    if (wr) begin
      case (offset)
        TMR_CTRL:     we.ctrl       = iomem.wstrb[0];
        TMR_PRESCALE: we.prescale   = 1'b1;
        TMR_COUNT:    we.count      = 1'b1;
        TMR_COMPARE:  we.compare    = 1'b1;
        TMR_STATUS:   we.status_clr = iomem.wstrb[0] && iomem.wdata[0];
        default:      we            = '0;
      endcase
    end
  end

  // Handshake: ready pulses the cycle after acceptance, rdata only meaningful then.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem.ready <= 1'b0;
      iomem.rdata <= 32'd0;
    end else begin
      iomem.ready <= accept;
      iomem.rdata <= (accept && (iomem.wstrb == 4'b0000)) ? rd_val : 32'd0;
    end
  end

  iomem_timer_core #(
    .PRESCALE_W(PRESCALE_W)
  ) u_core (
    .clk      (clk),
    .resetn   (resetn),
    .we       (we),
    .wdata    (wr_data),
    .ctrl     (ctrl),
    .prescale (prescale),
    .count    (count),
    .compare  (compare),
    .pending  (pending),
    .irq      (irq)
  );

endmodule

// File: tb/tb_iomem_timer.sv
// Testbench for iomem_timer: directed scenarios plus random bus traffic,
// all outputs compared every cycle against a behavioural model.
module tb_iomem_timer;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic irq;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   checking    = 1'b1;

  iomem_timer_if bus ();

  iomem_timer #(
    .BASE_ADDR  (32'h0300_0000),
    .PRESCALE_W (16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .iomem  (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Reference model state, starting at the reset values.
  logic [2:0]  m_ctrl  = 3'b000;
  logic [15:0] m_pre   = 16'd0;
  logic [15:0] m_pcnt  = 16'd0;
  logic [31:0] m_count = 32'd0;
  logic [31:0] m_cmp   = 32'hFFFF_FFFF;
  logic        m_pend  = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  logic        m_irq   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [7:0] off);
    case (off)
      8'h00:   return {29'd0, m_ctrl};
      8'h04:   return {16'd0, m_pre};
      8'h08:   return m_count;
      8'h0C:   return m_cmp;
      8'h10:   return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural model: one step of the timer rules per clock, bus writes applied last.
  always @(posedge clk or negedge resetn) begin : refModel
    logic        acc, wr, tick, hitCmp;
    logic [7:0]  off;
    logic [31:0] merged;
    if (!resetn) begin
      m_ctrl = 3'b000; m_pre = 16'd0; m_pcnt = 16'd0; m_count = 32'd0;
      m_cmp = 32'hFFFF_FFFF; m_pend = 1'b0; m_ready = 1'b0; m_rdata = 32'd0; m_irq = 1'b0;
    end else begin
      acc    = bus.valid && (bus.addr[31:8] == 24'h03_0000) && !m_ready;
      off    = {bus.addr[7:2], 2'b00};
      wr     = acc && (bus.wstrb != 4'b0000);
      tick   = m_ctrl[0] && (m_pcnt == m_pre);
      hitCmp = tick && (m_count == m_cmp);
      merged = modelRead(off);
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) merged[8*b +: 8] = bus.wdata[8*b +: 8];
      m_rdata = (acc && bus.wstrb == 4'b0000) ? modelRead(off) : 32'd0;
      m_ready = acc;
      m_irq   = m_pend && m_ctrl[2];
      if (!m_ctrl[0] || tick) m_pcnt = 16'd0;
      else                    m_pcnt = m_pcnt + 16'd1;
      if (tick) begin
        if (!hitCmp)        m_count = m_count + 32'd1;
        else if (m_ctrl[1]) m_count = 32'd0;
        else                m_ctrl[0] = 1'b0;
      end
      if (wr) begin
        case (off)
          8'h00: if (bus.wstrb[0]) m_ctrl = merged[2:0];
          8'h04: begin m_pre = merged[15:0]; m_pcnt = 16'd0; end
          8'h08: m_count = merged;
          8'h0C: m_cmp = merged;
          8'h10: if (bus.wstrb[0] && bus.wdata[0]) m_pend = 1'b0;
          default: ;
        endcase
      end
      if (hitCmp) m_pend = 1'b1;
    end
  end

  // Every cycle, compare the DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("ready", {31'd0, bus.ready}, {31'd0, m_ready});
      checkOutput("rdata", bus.rdata, m_rdata);
      checkOutput("irq",   {31'd0, irq},       {31'd0, m_irq});
    end
  end

  // Drive one bus transaction and wait a bounded number of cycles for ready.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output bit got, output int lat);
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = addr; bus.wstrb = wstrb; bus.wdata = wdata;
    got = 1'b0; rdata = 32'd0; lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      if (bus.ready) begin
        got = 1'b1;
        rdata = bus.rdata;
        break;
      end
    end
    bus.valid = 1'b0; bus.wstrb = 4'b0000;
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] rd;
    bit got;
    int lat;
    applyStimulus(32'h0300_0000 | {24'd0, off}, strb, data, rd, got, lat);
    checkOutput("write_ack", {31'd0, got}, 32'd1);
  endtask

  task automatic readReg(input logic [7:0] off, output logic [31:0] val);
    bit got;
    int lat;
    applyStimulus(32'h0300_0000 | {24'd0, off}, 4'b0000, 32'd0, val, got, lat);
    checkOutput("read_ack", {31'd0, got}, 32'd1);
  endtask

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] rd;
    bit          got;
    int          lat;
    logic [7:0]  offs [6];
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h20};

    bus.valid = 1'b0; bus.addr = 32'd0; bus.wstrb = 4'b0000; bus.wdata = 32'd0;

    // Reset held during a pending read of COUNT.
    @(negedge clk);
    bus.valid = 1'b1; bus.addr = 32'h0300_0008;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", {31'd0, bus.ready}, 32'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);
    checkOutput("rst_irq",   {31'd0, irq}, 32'd0);
    resetn = 1'b1;
    got = 1'b0; rd = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ready) begin got = 1'b1; rd = bus.rdata; break; end
    end
    bus.valid = 1'b0;
    checkOutput("held_read_ack", {31'd0, got}, 32'd1);
    checkOutput("held_read_count", rd, 32'd0);

    applyStimulus(32'h0300_000C, 4'b0000, 32'd0, rd, got, lat);
    checkOutput("compare_reset", rd, 32'hFFFF_FFFF);
    checkOutput("read_latency", 32'(lat), 32'd1);
    @(negedge clk);
    checkOutput("ready_one_cycle", {31'd0, bus.ready}, 32'd0);

    // Byte strobes, unmapped offset, out-of-window access.
    writeReg(8'h0C, 32'hAABB_CCDD, 4'b0101);
    readReg(8'h0C, rd);
    checkOutput("byte_strobe", rd, 32'hFFBB_FFDD);
    applyStimulus(32'h0300_0020, 4'b0000, 32'd0, rd, got, lat);
    checkOutput("unmapped_ack", {31'd0, got}, 32'd1);
    checkOutput("unmapped_data", rd, 32'd0);
    applyStimulus(32'h0400_0000, 4'b0000, 32'd0, rd, got, lat);
    checkOutput("miss_no_ready", {31'd0, got}, 32'd0);

    // Auto-reload with prescaler.
    writeReg(8'h04, 32'd3, 4'hF);
    writeReg(8'h0C, 32'd2, 4'hF);
    writeReg(8'h00, 32'h7, 4'hF);
    repeat (20) @(negedge clk);
    readReg(8'h10, rd);
    checkOutput("autoreload_pending", rd, 32'd1);
    checkOutput("autoreload_irq", {31'd0, irq}, 32'd1);
    readReg(8'h08, rd);
    checkOutput("autoreload_range", {31'd0, rd <= 32'd2}, 32'd1);
    writeReg(8'h00, 32'h0, 4'hF);
    writeReg(8'h10, 32'h1, 4'hF);

    // One-shot.
    writeReg(8'h08, 32'd0, 4'hF);
    writeReg(8'h04, 32'd0, 4'hF);
    writeReg(8'h0C, 32'd5, 4'hF);
    writeReg(8'h00, 32'h1, 4'hF);
    repeat (20) @(negedge clk);
    readReg(8'h08, rd);
    checkOutput("oneshot_count", rd, 32'd5);
    readReg(8'h00, rd);
    checkOutput("oneshot_ctrl", rd, 32'd0);
    readReg(8'h10, rd);
    checkOutput("oneshot_pending", rd, 32'd1);
    checkOutput("oneshot_irq", {31'd0, irq}, 32'd0);

    // W1C racing a match every cycle, then a lone W1C.
    writeReg(8'h10, 32'h1, 4'hF);
    writeReg(8'h0C, 32'd0, 4'hF);
    writeReg(8'h08, 32'd0, 4'hF);
    writeReg(8'h00, 32'h7, 4'hF);
    repeat (3) @(negedge clk);
    writeReg(8'h10, 32'h1, 4'hF);
    readReg(8'h10, rd);
    checkOutput("w1c_race_pending", rd, 32'd1);
    writeReg(8'h00, 32'h4, 4'hF);
    repeat (2) @(negedge clk);
    checkOutput("w1c_irq_before", {31'd0, irq}, 32'd1);
    writeReg(8'h10, 32'h1, 4'hF);
    readReg(8'h10, rd);
    checkOutput("w1c_alone_pending", rd, 32'd0);
    checkOutput("w1c_irq_after", {31'd0, irq}, 32'd0);

    // Wrap without a flag, then match at zero.
    writeReg(8'h00, 32'h0, 4'hF);
    writeReg(8'h0C, 32'd0, 4'hF);
    writeReg(8'h08, 32'hFFFF_FFFF, 4'hF);
    writeReg(8'h00, 32'h5, 4'hF);
    repeat (10) @(negedge clk);
    readReg(8'h08, rd);
    checkOutput("wrap_count", rd, 32'd0);
    readReg(8'h10, rd);
    checkOutput("wrap_pending", rd, 32'd1);
    readReg(8'h00, rd);
    checkOutput("wrap_ctrl", rd, 32'h4);
    writeReg(8'h10, 32'h1, 4'hF);
    writeReg(8'h00, 32'h0, 4'hF);

    // COUNT write coincident with a tick wins.
    writeReg(8'h0C, 32'h10, 4'hF);
    writeReg(8'h08, 32'h100, 4'hF);
    writeReg(8'h00, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    writeReg(8'h08, 32'h10, 4'hF);
    repeat (5) @(negedge clk);
    readReg(8'h08, rd);
    checkOutput("count_write_wins", rd, 32'h10);
    readReg(8'h00, rd);
    checkOutput("count_write_ctrl", rd, 32'h0);

    // Random bus traffic; the per-cycle model comparison does the checking.
    for (int n = 0; n < 400; n++) begin
      addr = 32'h0300_0000 | {24'd0, offs[$urandom_range(0, 5)]} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 8) addr = 32'h0400_0000 | addr[7:0];
      strb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      case ({addr[7:2], 2'b00})
        8'h04:        data = 32'($urandom_range(0, 3));
        8'h08, 8'h0C: data = 32'($urandom_range(0, 12));
        default:      data = $urandom;
      endcase
      applyStimulus(addr, strb, data, rd, got, lat);
      checkOutput("rand_ack", {31'd0, got}, {31'd0, addr[31:8] == 24'h03_0000});
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
